// File: rtl/fetch_decode_unit.sv
// Fetch/decode front end: program counter register, PC+PC_INC incrementer and the
// combinational main control unit of the 5-stage ARM-subset pipeline.
module fetch_decode_unit #(
    parameter logic [31:0] PC_RESET = 32'h0000_0000,
    parameter int unsigned PC_INC   = 4
) (
    input  logic        clk,
    input  logic        Reset,
    input  logic        E,
    input  logic [31:0] pc_in,
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus4,
    input  logic [31:0] instruction,
    output logic        rf_en,
    output logic [3:0]  alu_op,
    output logic        Load,
    output logic        branch_link,
    output logic        s_bit,
    output logic        rw,
    output logic        size,
    output logic        datamem_en
);

    typedef enum logic [3:0] {
        OP_AND = 4'b0000, OP_EOR = 4'b0001, OP_SUB = 4'b0010, OP_RSB = 4'b0011,
        OP_ADD = 4'b0100, OP_ADC = 4'b0101, OP_SBC = 4'b0110, OP_RSC = 4'b0111,
        OP_TST = 4'b1000, OP_TEQ = 4'b1001, OP_CMP = 4'b1010, OP_CMN = 4'b1011,
        OP_ORR = 4'b1100, OP_MOV = 4'b1101, OP_BIC = 4'b1110, OP_MVN = 4'b1111
    } dp_op_t;

    typedef enum logic [3:0] {
        ALU_ADD = 4'b0000, ALU_ADC = 4'b0001, ALU_SUB = 4'b0010, ALU_SBC = 4'b0011,
        ALU_RSB = 4'b0100, ALU_RSC = 4'b0101, ALU_AND = 4'b0110, ALU_ORR = 4'b0111,
        ALU_EOR = 4'b1000, ALU_MOV = 4'b1010, ALU_MVN = 4'b1011, ALU_BIC = 4'b1100
    } alu_code_t;

    dp_op_t dp_op;

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset)
            pc_out <= PC_RESET;
        else if (E)
            pc_out <= pc_in;
    end

    assign pc_plus4 = pc_out + 32'(PC_INC);

    assign dp_op = dp_op_t'(instruction[24:21]);

    always_comb begin
        rf_en       = 1'b0;
        alu_op      = '0;
        Load        = 1'b0;
        branch_link = 1'b0;
        s_bit       = 1'b0;
        rw          = 1'b0;
        size        = 1'b0;
        datamem_en  = 1'b0;
        // The all-zero word would otherwise decode as ANDEQ r0,r0,r0; it is the pipeline NOP.
        if (instruction != '0) begin
            case (instruction[27:26])
                2'b00: begin
                    s_bit = instruction[20];
                    rf_en = (instruction[24:23] != 2'b10);
                    case (dp_op)
                        OP_AND, OP_TST: alu_op = ALU_AND;
                        OP_EOR, OP_TEQ: alu_op = ALU_EOR;
                        OP_SUB, OP_CMP: alu_op = ALU_SUB;
                        OP_RSB:         alu_op = ALU_RSB;
                        OP_ADD, OP_CMN: alu_op = ALU_ADD;
                        OP_ADC:         alu_op = ALU_ADC;
                        OP_SBC:         alu_op = ALU_SBC;
                        OP_RSC:         alu_op = ALU_RSC;
                        OP_ORR:         alu_op = ALU_ORR;
                        OP_MOV:         alu_op = ALU_MOV;
                        OP_BIC:         alu_op = ALU_BIC;
                        OP_MVN:         alu_op = ALU_MVN;
                        default:        alu_op = '0;
                    endcase
                end
                2'b01: begin
                    datamem_en = 1'b1;
                    Load       = instruction[20];
                    rf_en      = instruction[20];
                    rw         = ~instruction[20];
                    size       = instruction[22];
                    alu_op     = instruction[23] ? ALU_ADD : ALU_SUB;
                end
                2'b10: begin
                    if (instruction[25]) begin
                        branch_link = instruction[24];
                        rf_en       = instruction[24];
                        alu_op      = ALU_ADD;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_decode_unit.sv
// Randomized self-checking bench for fetch_decode_unit against a behavioural PC/decode model.
module tb_fetch_decode_unit;

    typedef struct packed {
        logic       rf_en;
        logic [3:0] alu_op;
        logic       load;
        logic       bl;
        logic       s;
        logic       rw;
        logic       size;
        logic       dmem;
    } ctl_t;

    logic        clk = 1'b0;
    logic        Reset;
    logic        E;
    logic [31:0] pc_in;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4;
    logic [31:0] instruction;
    logic        rf_en, Load, branch_link, s_bit, rw, size, datamem_en;
    logic [3:0]  alu_op;

    int total = 0;
    int bad   = 0;
    logic [31:0] pc_model;

    // ALU code for each data-processing opcode, indexed by instruction[24:21]
    logic [3:0] dp_tbl [16] = '{4'b0110, 4'b1000, 4'b0010, 4'b0100, 4'b0000, 4'b0001, 4'b0011, 4'b0101,
                                4'b0110, 4'b1000, 4'b0010, 4'b0000, 4'b0111, 4'b1010, 4'b1100, 4'b1011};

    fetch_decode_unit #(.PC_RESET(32'h0000_0000), .PC_INC(4)) dut (
        .clk(clk), .Reset(Reset), .E(E), .pc_in(pc_in), .pc_out(pc_out), .pc_plus4(pc_plus4),
        .instruction(instruction), .rf_en(rf_en), .alu_op(alu_op), .Load(Load),
        .branch_link(branch_link), .s_bit(s_bit), .rw(rw), .size(size), .datamem_en(datamem_en)
    );

    always #5 clk = ~clk;

    function automatic ctl_t observed();
        return {rf_en, alu_op, Load, branch_link, s_bit, rw, size, datamem_en};
    endfunction

    function automatic ctl_t model(input logic [31:0] ins);
        ctl_t m = '0;
        logic [3:0] op = ins[24:21];
        logic [2:0] cls = ins[27:25];
        if (ins == 32'h0) return m;
        if (cls == 3'b000 || cls == 3'b001) begin
            m.alu_op = dp_tbl[op];
            m.s      = ins[20];
            m.rf_en  = !(op >= 4'd8 && op <= 4'd11);
        end else if (cls == 3'b010 || cls == 3'b011) begin
            m.dmem   = 1'b1;
            m.load   = ins[20];
            m.rf_en  = ins[20];
            m.rw     = !ins[20];
            m.size   = ins[22];
            m.alu_op = ins[23] ? 4'd0 : 4'd2;
        end else if (cls == 3'b101) begin
            m.bl     = ins[24];
            m.rf_en  = ins[24];
        end
        return m;
    endfunction

    task automatic test_reset();
        Reset = 1'b1; E = 1'b0; pc_in = '0; instruction = '0;
        #12;
        total++;
        if (pc_out !== 32'h0 || pc_plus4 !== 32'h4) begin
            bad++;
            $display("FAIL reset_state: pc_out=%h pc_plus4=%h required 00000000/00000004", pc_out, pc_plus4);
        end
        total++;
        if (observed() !== ctl_t'('0)) begin
            bad++;
            $display("FAIL nop_outputs: got %b required all zero", observed());
        end
        @(negedge clk); Reset = 1'b0; pc_model = 32'h0;
    endtask

    task automatic test_count_and_midrun_reset();
        E = 1'b1;
        repeat (3) begin
            @(negedge clk); pc_in = pc_plus4;
        end
        @(negedge clk); pc_in = 32'h1234_5678;
        #2 Reset = 1'b1;
        #1;
        total++;
        if (pc_out !== 32'h0 || pc_plus4 !== 32'h4) begin
            bad++;
            $display("FAIL midrun_reset: pc_out=%h pc_plus4=%h required 00000000/00000004", pc_out, pc_plus4);
        end
        @(posedge clk); #1;
        total++;
        if (pc_out !== 32'h0) begin
            bad++;
            $display("FAIL reset_beats_edge: pc_out=%h required 00000000", pc_out);
        end
        @(negedge clk); Reset = 1'b0;
        for (int unsigned i = 1; i <= 3; i++) begin
            pc_in = pc_plus4;
            @(posedge clk); #1;
            total++;
            if (pc_out !== 32'(4 * i)) begin
                bad++;
                $display("FAIL count_step%0d: pc_out=%h required %h", i, pc_out, 32'(4 * i));
            end
            @(negedge clk);
        end
    endtask

    task automatic test_hold_and_wrap();
        logic [31:0] held;
        held = pc_out;
        E = 1'b0; pc_in = 32'h40;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (pc_out !== held) begin
            bad++;
            $display("FAIL hold: pc_out=%h required %h", pc_out, held);
        end
        @(negedge clk); E = 1'b1;
        @(posedge clk); #1;
        total++;
        if (pc_out !== 32'h40) begin
            bad++;
            $display("FAIL load_40: pc_out=%h required 00000040", pc_out);
        end
        @(negedge clk); pc_in = 32'hFFFF_FFFC;
        @(posedge clk); #1;
        total++;
        if (pc_out !== 32'hFFFF_FFFC || pc_plus4 !== 32'h0) begin
            bad++;
            $display("FAIL wrap: pc_out=%h pc_plus4=%h required fffffffc/00000000", pc_out, pc_plus4);
        end
        @(negedge clk); E = 1'b0;
    endtask

    task automatic test_directed_decode();
        logic [31:0] ins [7] = '{32'hE0910002, 32'hE3500000, 32'hE5912004, 32'hE5412004,
                                 32'hEB000004, 32'hEA000004, 32'h00000000};
        ctl_t exp [7] = '{
            '{rf_en:1'b1, alu_op:4'b0000, load:1'b0, bl:1'b0, s:1'b1, rw:1'b0, size:1'b0, dmem:1'b0},
            '{rf_en:1'b0, alu_op:4'b0010, load:1'b0, bl:1'b0, s:1'b1, rw:1'b0, size:1'b0, dmem:1'b0},
            '{rf_en:1'b1, alu_op:4'b0000, load:1'b1, bl:1'b0, s:1'b0, rw:1'b0, size:1'b0, dmem:1'b1},
            '{rf_en:1'b0, alu_op:4'b0010, load:1'b0, bl:1'b0, s:1'b0, rw:1'b1, size:1'b1, dmem:1'b1},
            '{rf_en:1'b1, alu_op:4'b0000, load:1'b0, bl:1'b1, s:1'b0, rw:1'b0, size:1'b0, dmem:1'b0},
            ctl_t'('0),
            ctl_t'('0)};
        for (int i = 0; i < 7; i++) begin
            instruction = ins[i];
            #1;
            total++;
            if (observed() !== exp[i]) begin
                bad++;
                $display("FAIL directed_%h: got %b required %b", ins[i], observed(), exp[i]);
            end
        end
    endtask

    task automatic test_dp_sweep();
        for (int op = 0; op < 16; op++) begin
            for (int s = 0; s < 2; s++) begin
                instruction = 32'hE000_0000 | (32'(op) << 21) | (32'(s) << 20) | 32'h0001_2003;
                #1;
                total++;
                if (alu_op !== dp_tbl[op] || s_bit !== 1'(s) || rf_en !== !(op >= 8 && op <= 11) ||
                    datamem_en !== 1'b0 || Load !== 1'b0 || branch_link !== 1'b0 || rw !== 1'b0 || size !== 1'b0) begin
                    bad++;
                    $display("FAIL dp_sweep op=%0d s=%0d: got %b required alu=%b s=%0d rf_en=%0d",
                             op, s, observed(), dp_tbl[op], s, !(op >= 8 && op <= 11));
                end
            end
        end
    endtask

    task automatic test_random_decode();
        ctl_t exp;
        for (int i = 0; i < 300; i++) begin
            instruction = ($urandom_range(0, 19) == 0) ? 32'h0 : $urandom;
            #1;
            exp = model(instruction);
            total++;
            if (observed() !== exp) begin
                bad++;
                $display("FAIL random_decode %h: got %b required %b", instruction, observed(), exp);
            end
        end
    endtask

    task automatic test_random_pc();
        logic r;
        pc_model = pc_out;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            E = 1'($urandom);
            pc_in = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFC : $urandom;
            r = ($urandom_range(0, 15) == 0);
            if (r) begin
                Reset = 1'b1;
                #1;
                pc_model = 32'h0;
                total++;
                if (pc_out !== pc_model || pc_plus4 !== 32'h4) begin
                    bad++;
                    $display("FAIL random_reset: pc_out=%h pc_plus4=%h required 00000000/00000004", pc_out, pc_plus4);
                end
                Reset = 1'b0;
            end
            @(posedge clk); #1;
            if (E) pc_model = pc_in;
            total++;
            if (pc_out !== pc_model || pc_plus4 !== pc_model + 32'd4) begin
                bad++;
                $display("FAIL random_pc: pc_out=%h pc_plus4=%h required %h/%h", pc_out, pc_plus4, pc_model, pc_model + 32'd4);
            end
        end
    endtask

    initial begin
        test_reset();
        test_count_and_midrun_reset();
        test_hold_and_wrap();
        test_directed_decode();
        test_dp_sweep();
        test_random_decode();
        test_random_pc();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
